// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_if
//  Description : Push-button bundle: raw active-low key levels in, debounced
//                level and one-cycle press / release / long-press events out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_if #(
    parameter int N_KEYS = 4
) ();

    logic [N_KEYS-1:0] key_n;        // raw button levels, 0 = pressed
    logic [N_KEYS-1:0] key_state;    // debounced level, 1 = pressed
    logic [N_KEYS-1:0] key_press;    // one-cycle pulse per accepted press
    logic [N_KEYS-1:0] key_release;  // one-cycle pulse per accepted release
    logic [N_KEYS-1:0] key_long;     // one-cycle pulse after a long hold

    // Side that owns the buttons (board / testbench)
    modport master (
        output key_n,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    // Side that debounces (the key_debounce block)
    modport slave (
        input  key_n,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );

endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : N_KEYS independent push-button debouncers. Each key is
//                synchronised by two flops, then a four-state FSM accepts a
//                press or release only after DEBOUNCE_CYCLES stable samples
//                and flags a long press after LONG_CYCLES cycles held.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave keys
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; the hold
    // counter must be able to hold LONG_CYCLES itself (saturation value).
    localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_HOLD_W = $clog2(LONG_CYCLES) + 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_ONE   = c_DB_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_PRE = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers. Reset value is 1 so that a key still held at
    // reset release is seen as a fresh falling edge and re-debounced.
    // ------------------------------------------------------------------------
    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;

    // Bring the asynchronous key levels into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= keys.key_n;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // One fully independent debouncer per key
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key

        state_t                r_state;
        state_t                w_state_nxt;
        logic [c_DB_W-1:0]     r_db;
        logic [c_DB_W-1:0]     w_db_nxt;
        logic [c_HOLD_W-1:0]   r_hold;
        logic [c_HOLD_W-1:0]   w_hold_nxt;
        logic                  r_kstate;
        logic                  w_kstate_nxt;
        logic                  r_press;
        logic                  w_press_nxt;
        logic                  r_release;
        logic                  w_release_nxt;
        logic                  r_long;
        logic                  w_long_nxt;
        logic                  w_s2;

        // Synchronised level seen by this key's FSM (1 = released)
        assign w_s2 = r_sync2[k];

        // State, counters and registered event outputs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_db      <= '0;
                r_hold    <= '0;
                r_kstate  <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_db      <= w_db_nxt;
                r_hold    <= w_hold_nxt;
                r_kstate  <= w_kstate_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
                r_long    <= w_long_nxt;
            end
        end

        // Next-state, counter updates and event decode for this key
        always_comb begin
            w_state_nxt   = r_state;
            w_db_nxt      = r_db;
            w_hold_nxt    = r_hold;
            w_kstate_nxt  = r_kstate;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            w_long_nxt    = 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_s2) begin
                        w_state_nxt = S_PRESS_WAIT;
                        w_db_nxt    = '0;
                    end
                end

                S_PRESS_WAIT: begin
                    if (w_s2) begin
                        // Bounce back high: forget the partial press
                        w_state_nxt = S_IDLE;
                        w_db_nxt    = '0;
                    end else if (r_db == c_DB_LAST) begin
                        w_state_nxt  = S_PRESSED;
                        w_kstate_nxt = 1'b1;
                        w_press_nxt  = 1'b1;
                        w_hold_nxt   = '0;
                    end else begin
                        w_db_nxt = r_db + c_DB_ONE;
                    end
                end

                S_PRESSED: begin
                    // Hold time saturates so the long event fires only once
                    if (r_hold != c_HOLD_MAX) begin
                        w_hold_nxt = r_hold + c_HOLD_ONE;
                    end
                    if (r_hold == c_HOLD_PRE) begin
                        w_long_nxt = 1'b1;
                    end
                    if (w_s2) begin
                        w_state_nxt = S_RELEASE_WAIT;
                        w_db_nxt    = '0;
                    end
                end

                S_RELEASE_WAIT: begin
                    // Hold counter is frozen here; a short release glitch
                    // returns to PRESSED and the hold time simply resumes.
                    if (!w_s2) begin
                        w_state_nxt = S_PRESSED;
                    end else if (r_db == c_DB_LAST) begin
                        w_state_nxt   = S_IDLE;
                        w_kstate_nxt  = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_db_nxt = r_db + c_DB_ONE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_db_nxt    = '0;
                end
            endcase
        end

        assign keys.key_state[k]   = r_kstate;
        assign keys.key_press[k]   = r_press;
        assign keys.key_release[k] = r_release;
        assign keys.key_long[k]    = r_long;

    end : g_key

endmodule
`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent push-button inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): stable-input cycles required to accept a press or release; legal range >= 2.
REQ-003 Parameter LONG_CYCLES, default 50000000 (1 s at 50 MHz): cycles in PRESSED before a long-press event; legal range >= 2.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 key_n  input  N_KEYS  raw button levels; 0 = pressed; asynchronous to clk.
REQ-008 key_state  output  N_KEYS  debounced level; 1 = pressed.
REQ-009 key_press  output  N_KEYS  one-cycle pulse per accepted press.
REQ-010 key_release  output  N_KEYS  one-cycle pulse per accepted release.
REQ-011 key_long  output  N_KEYS  one-cycle pulse when a press has been held LONG_CYCLES.

Function
REQ-012 Each key_n bit SHALL pass through a 2-flop synchronizer; the FSM acts only on the second stage (s2).
REQ-013 Each key SHALL have its own FSM, debounce counter (ceil(log2(DEBOUNCE_CYCLES)) bits) and hold counter (ceil(log2(LONG_CYCLES))+1 bits); keys are fully independent, and any number of bits MAY pulse in the same cycle.
REQ-014 FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-015 IDLE: s2=0 -> PRESS_WAIT, debounce counter cleared to 0; otherwise stay.
REQ-016 PRESS_WAIT: s2=1 -> IDLE, counter 0, no output; s2=0 and counter==DEBOUNCE_CYCLES-1 -> PRESSED, key_state<=1, key_press pulse, hold counter cleared; otherwise counter+1.
REQ-017 PRESSED: hold counter increments each cycle and saturates at LONG_CYCLES; key_long pulses on the edge where the counter goes from LONG_CYCLES-1 to LONG_CYCLES, exactly once per press (no auto-repeat); s2=1 -> RELEASE_WAIT, debounce counter 0.
REQ-018 RELEASE_WAIT: s2=0 -> PRESSED, no press pulse, hold counter retained and not cleared; s2=1 and counter==DEBOUNCE_CYCLES-1 -> IDLE, key_state<=0, key_release pulse; otherwise counter+1. Hold counter frozen in this state.
REQ-019 Latency: with key_n held stable low from before rising edge 1, key_press and key_state SHALL be registered high at edge DEBOUNCE_CYCLES+3; release latency identical, measured from the edge that first samples key_n high.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES (after synchronization) SHALL produce no output change.
REQ-021 key_press, key_release and key_long SHALL be registered outputs, high for exactly one cycle per event.
REQ-022 key_state SHALL change only together with a key_press or key_release pulse on the same edge.

Reset
REQ-023 While rst=1: all FSMs IDLE, all counters 0, synchronizer flops 1 (released), all outputs 0.
REQ-024 Reset asserted mid-operation SHALL abort every FSM immediately without emitting a release pulse.
REQ-025 A key still held after reset deassertion SHALL be reported as a new press after the normal latency.

Verification (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, N_KEYS=4)
REQ-026 Clean press: key_n[0] low from edge 1 -> key_press[0] pulse and key_state[0]=1 at edge 11; release gives key_release[0] pulse 11 edges after the first high sample.
REQ-027 Bounce: key_n[1] toggles every 3 cycles for 40 cycles, then held low -> exactly one key_press[1], 11 edges after the final low transition is sampled; no other pulses.
REQ-028 Long press: key_n[2] held low for 60 cycles -> key_press[2] at edge 11, key_long[2] single pulse at edge 43, no further key_long.
REQ-029 Release glitch: key_n[3] high for 5 cycles while PRESSED -> no key_release[3], no second key_press[3], key_state[3] stays 1, hold count resumes.
REQ-030 Simultaneous: key_n[0] and key_n[3] fall on the same edge -> key_press = 4'b1001 for one cycle.
REQ-031 Reset mid-press: rst=1 pulse while key 0 is PRESSED and still held -> outputs 0 during reset, no key_release pulse, then key_press[0] 11 edges after rst deasserts.
